// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - shared types and default address map for mem_region_ctrl
package mem_map_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        CFG      = 2'd1,
        RUN      = 2'd2,
        HALTED   = 2'd3
    } state_t;

    localparam logic [1:0] CFG_SEL_BOT = 2'b00;
    localparam logic [1:0] CFG_SEL_TOP = 2'b01;
    localparam logic [1:0] CFG_SEL_EN  = 2'b10;
    localparam logic [1:0] CFG_SEL_RSV = 2'b11;

    localparam logic [63:0] DEF_IM_BOT = 64'h0000_0000_0000_0000;
    localparam logic [63:0] DEF_IM_TOP = 64'h0000_0007_FFFF_FFFF;
    localparam logic [63:0] DEF_DM_BOT = 64'h0000_0008_0000_0000;
    localparam logic [63:0] DEF_DM_TOP = 64'h0000_000F_FFFF_FFFF;

endpackage

// File: rtl/mem_region_ctrl_if.sv
// rtl/mem_region_ctrl_if.sv - config write and address lookup bus
interface mem_region_ctrl_if #(
    parameter int ADDR_W      = 64,
    parameter int NUM_REGIONS = 4
);
    localparam int IDX_W = $clog2(NUM_REGIONS);

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [1:0]        cfg_sel;
    logic [ADDR_W-1:0] cfg_data;
    logic              cfg_ack;
    logic              cfg_err;
    logic              lk_valid;
    logic [ADDR_W-1:0] lk_addr;
    logic              lk_rvalid;
    logic              lk_hit;
    logic [IDX_W-1:0]  lk_region;

    modport master (
        output cfg_we, cfg_idx, cfg_sel, cfg_data, lk_valid, lk_addr,
        input  cfg_ack, cfg_err, lk_rvalid, lk_hit, lk_region
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_sel, cfg_data, lk_valid, lk_addr,
        output cfg_ack, cfg_err, lk_rvalid, lk_hit, lk_region
    );

endinterface

// File: rtl/region_match.sv
// rtl/region_match.sv - single-window inclusive range comparator
module region_match #(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] bot,
    input  logic [ADDR_W-1:0] top,
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range
);

    // Both bounds are inclusive so an all-ones top still covers the last address
    assign in_range = en && (addr >= bot) && (addr <= top);

endmodule

// File: rtl/mem_region_ctrl.sv
// rtl/mem_region_ctrl.sv - programmable region table, core run FSM and lookup port
module mem_region_ctrl
    import mem_map_pkg::*;
#(
    parameter int ADDR_W      = 64,
    parameter int NUM_REGIONS = 4,
    parameter int RST_CYCLES  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          sw_reset,
    input  logic                          start,
    input  logic                          halt,
    mem_region_ctrl_if.slave              bus,
    output logic                          core_reset,
    output logic                          continue_val,
    output state_t                        state_o,
    output logic [NUM_REGIONS*ADDR_W-1:0] region_bot,
    output logic [NUM_REGIONS*ADDR_W-1:0] region_top
);

    localparam int IDX_W = $clog2(NUM_REGIONS);
    localparam int CNT_W = $clog2(RST_CYCLES + 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]        bot_q [NUM_REGIONS];
    logic [ADDR_W-1:0]        bot_d [NUM_REGIONS];
    logic [ADDR_W-1:0]        top_q [NUM_REGIONS];
    logic [ADDR_W-1:0]        top_d [NUM_REGIONS];
    logic [NUM_REGIONS-1:0]   en_q, en_d;
    logic                     cfg_ack_q, cfg_ack_d;
    logic                     cfg_err_q, cfg_err_d;
    logic                     lk_rvalid_q, lk_rvalid_d;
    logic                     lk_hit_q, lk_hit_d;
    logic [IDX_W-1:0]         lk_region_q, lk_region_d;

    logic                     cfg_ok;
    logic                     wr_legal;
    logic                     wr_acc;
    logic                     start_err;
    logic [NUM_REGIONS-1:0]   in_range;
    logic                     hit_c;
    logic [IDX_W-1:0]         idx_c;

    function automatic logic [ADDR_W-1:0] def_bot(input int i);
        return (i == 1) ? ADDR_W'(DEF_DM_BOT) : ADDR_W'(DEF_IM_BOT);
    endfunction

    function automatic logic [ADDR_W-1:0] def_top(input int i);
        if (i == 0) return ADDR_W'(DEF_IM_TOP);
        if (i == 1) return ADDR_W'(DEF_DM_TOP);
        return '0;
    endfunction

    // Table is legal when something is enabled, every enabled window is well formed and none overlap
    always_comb begin
        cfg_ok = |en_q;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (en_q[i] && (bot_q[i] > top_q[i])) cfg_ok = 1'b0;
            for (int j = i + 1; j < NUM_REGIONS; j++) begin
                if (en_q[i] && en_q[j] && (bot_q[i] <= top_q[j]) && (bot_q[j] <= top_q[i]))
                    cfg_ok = 1'b0;
            end
        end
    end

    // Writes land only in CFG; reserved selector or out-of-range index is rejected
    always_comb begin
        wr_legal  = (state_q == CFG) && (bus.cfg_sel != CFG_SEL_RSV) &&
                    (32'(bus.cfg_idx) < NUM_REGIONS);
        wr_acc    = bus.cfg_we && wr_legal;
        start_err = start && !sw_reset && (state_q == CFG) && !cfg_ok;
        cfg_ack_d = wr_acc;
        cfg_err_d = (bus.cfg_we && !wr_legal) || start_err;
        bot_d     = bot_q;
        top_d     = top_q;
        en_d      = en_q;
        if (wr_acc) begin
            case (bus.cfg_sel)
                CFG_SEL_BOT: bot_d[bus.cfg_idx] = bus.cfg_data;
                CFG_SEL_TOP: top_d[bus.cfg_idx] = bus.cfg_data;
                CFG_SEL_EN:  en_d[bus.cfg_idx]  = bus.cfg_data[0];
                default:     ;
            endcase
        end
    end

    // Core sequencing: sw_reset wins over halt, halt wins over start
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sw_reset) begin
            state_d = RST_HOLD;
            cnt_d   = '0;
        end else begin
            case (state_q)
                RST_HOLD: begin
                    if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                        state_d = CFG;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CFG:     if (start && cfg_ok) state_d = RUN;
                RUN:     if (halt) state_d = HALTED;
                HALTED:  if (!halt && start) state_d = RUN;
                default: state_d = RST_HOLD;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
            region_match #(.ADDR_W(ADDR_W)) u_match (
                .bot      (bot_q[g]),
                .top      (top_q[g]),
                .en       (en_q[g]),
                .addr     (bus.lk_addr),
                .in_range (in_range[g])
            );
            assign region_bot[g*ADDR_W +: ADDR_W] = bot_q[g];
            assign region_top[g*ADDR_W +: ADDR_W] = top_q[g];
        end
    endgenerate

    // Lowest matching index wins; scan downward so the last assignment is the lowest
    always_comb begin
        hit_c = 1'b0;
        idx_c = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (in_range[i]) begin
                hit_c = 1'b1;
                idx_c = IDX_W'(i);
            end
        end
        lk_rvalid_d = bus.lk_valid;
        lk_hit_d    = bus.lk_valid ? hit_c : lk_hit_q;
        lk_region_d = bus.lk_valid ? idx_c : lk_region_q;
    end

    // State, table and response registers; only reset_n restores the default map
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            cfg_ack_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
            lk_rvalid_q <= 1'b0;
            lk_hit_q    <= 1'b0;
            lk_region_q <= '0;
            for (int i = 0; i < NUM_REGIONS; i++) begin
                bot_q[i] <= def_bot(i);
                top_q[i] <= def_top(i);
                en_q[i]  <= (i < 2);
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_ack_q   <= cfg_ack_d;
            cfg_err_q   <= cfg_err_d;
            lk_rvalid_q <= lk_rvalid_d;
            lk_hit_q    <= lk_hit_d;
            lk_region_q <= lk_region_d;
            bot_q       <= bot_d;
            top_q       <= top_d;
            en_q        <= en_d;
        end
    end

    assign bus.cfg_ack   = cfg_ack_q;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.lk_rvalid = lk_rvalid_q;
    assign bus.lk_hit    = lk_hit_q;
    assign bus.lk_region = lk_region_q;
    assign core_reset    = (state_q == RST_HOLD) || (state_q == CFG);
    assign continue_val  = (state_q == RUN);
    assign state_o       = state_q;

endmodule
